// File: rtl/cpu_pkg.sv
// Shared CPU datapath types: register-source descriptors, write-back port payloads, bypass constants.
package cpu_pkg;

  localparam int unsigned LRF_AW    = 5;
  localparam int unsigned LRF_DW    = 32;
  localparam int unsigned TNEW_W    = 2;
  localparam int unsigned FWD_CNT_W = 16;

  typedef logic [LRF_DW-1:0] lrf_data;

  // src=1 marks an immediate/non-register operand
  typedef struct packed {
    logic              src;
    logic [LRF_AW-1:0] addr;
  } reg_info;

  typedef struct packed {
    logic [LRF_AW-1:0] addr;
    logic [TNEW_W-1:0] tnew;
    lrf_data           data;
  } wr_reg_info;

endpackage

// File: rtl/forward_src_lane.sv
// One source operand: youngest-producer priority match over all write-back ports plus a stall hold register.
module forward_src_lane
  import cpu_pkg::*;
#(
  parameter int unsigned NSTAGE = 5,
  parameter int unsigned NWP    = 2,
  parameter int unsigned DW     = LRF_DW,
  parameter int unsigned TW     = TNEW_W
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             stall,
  input  logic                             flush,
  input  reg_info                          src_i,
  input  logic [DW-1:0]                    src_data_i,
  input  wr_reg_info [NSTAGE-1:0][NWP-1:0] wd_i,
  output logic [DW-1:0]                    fwd_data_c,
  output logic                             fwd_hit_c,
  output logic                             src_hazard_c,
  output logic                             hold_valid_o
);

  logic          match_found;
  logic [TW-1:0] match_tnew;
  logic [DW-1:0] match_data;

  logic [DW-1:0] hold_d, hold_q;
  logic          hold_valid_d, hold_valid_q;

  // Scan oldest to youngest so the youngest match overwrites the rest
  always_comb begin
    match_found = 1'b0;
    match_tnew  = '0;
    match_data  = '0;
    for (int i = int'(NSTAGE) - 1; i >= 0; i--) begin
      for (int p = 0; p < int'(NWP); p++) begin
        if (!src_i.src && (src_i.addr != '0) && (src_i.addr == wd_i[i][p].addr)) begin
          match_found = 1'b1;
          match_tnew  = TW'(wd_i[i][p].tnew);
          match_data  = DW'(wd_i[i][p].data);
        end
      end
    end
  end

  always_comb begin
    fwd_hit_c    = match_found && (match_tnew == '0);
    src_hazard_c = match_found && (match_tnew != '0);
    if (fwd_hit_c)         fwd_data_c = match_data;
    else if (hold_valid_q) fwd_data_c = hold_q;
    else                   fwd_data_c = src_data_i;
  end

  always_comb begin
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    if (flush) begin
      hold_d       = '0;
      hold_valid_d = 1'b0;
    end else if (stall) begin
      if (fwd_hit_c) begin
        hold_d       = match_data;
        hold_valid_d = 1'b1;
      end
    end else begin
      hold_d       = '0;
      hold_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
    end else begin
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
    end
  end

  assign hold_valid_o = hold_valid_q;

endmodule

// File: rtl/forward_net_param.sv
// Parametrised operand bypass network: per-source lanes, stall request and saturating hazard-cycle counter.
module forward_net_param
  import cpu_pkg::*;
#(
  parameter int unsigned NSRC   = 2,
  parameter int unsigned NSTAGE = 5,
  parameter int unsigned NWP    = 2,
  parameter int unsigned DW     = LRF_DW,
  parameter int unsigned TW     = TNEW_W
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             stall,
  input  logic                             flush,
  input  reg_info    [NSRC-1:0]            src,
  input  logic       [NSRC-1:0][DW-1:0]    src_data,
  input  wr_reg_info [NSTAGE-1:0][NWP-1:0] wd,
  output logic       [NSRC-1:0][DW-1:0]    fwd_data,
  output logic       [NSRC-1:0]            fwd_hit,
  output logic       [NSRC-1:0]            src_hazard,
  output logic                             stall_req,
  output logic       [NSRC-1:0]            hold_valid,
  output logic       [FWD_CNT_W-1:0]       hazard_cnt
);

  logic [FWD_CNT_W-1:0] hazard_cnt_d, hazard_cnt_q;

  for (genvar s = 0; s < NSRC; s++) begin : g_lane
    forward_src_lane #(
      .NSTAGE (NSTAGE),
      .NWP    (NWP),
      .DW     (DW),
      .TW     (TW)
    ) u_lane (
      .clk          (clk),
      .reset        (reset),
      .stall        (stall),
      .flush        (flush),
      .src_i        (src[s]),
      .src_data_i   (src_data[s]),
      .wd_i         (wd),
      .fwd_data_c   (fwd_data[s]),
      .fwd_hit_c    (fwd_hit[s]),
      .src_hazard_c (src_hazard[s]),
      .hold_valid_o (hold_valid[s])
    );
  end

  assign stall_req = |src_hazard;

  always_comb begin
    hazard_cnt_d = hazard_cnt_q;
    if (stall_req && (hazard_cnt_q != '1)) hazard_cnt_d = hazard_cnt_q + FWD_CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) hazard_cnt_q <= '0;
    else       hazard_cnt_q <= hazard_cnt_d;
  end

  assign hazard_cnt = hazard_cnt_q;

endmodule
